// File: rtl/xrisc_mmio_pkg.sv
// xrisc_mmio_pkg
//   Shared definitions for the data-memory / MMIO responder:
//   - MMIO register addresses (word aligned)
//   - STATUS register bit positions
//   - address-decode region enum plus the decode helper
package xrisc_mmio_pkg;

  localparam logic [31:0] TXDATA_ADDR = 32'h8000_0000;
  localparam logic [31:0] STATUS_ADDR = 32'h8000_0004;
  localparam logic [31:0] CYCLES_ADDR = 32'h8000_0008;

  // STATUS = {24'b0, overflow, full, empty, count[4:0]}
  localparam int STAT_OVERFLOW_BIT = 7;
  localparam int STAT_FULL_BIT     = 6;
  localparam int STAT_EMPTY_BIT    = 5;
  localparam int STAT_COUNT_LSB    = 0;
  localparam int STAT_COUNT_W      = 5;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_TX,
    REG_STATUS,
    REG_CYCLES,
    REG_NONE
  } region_e;

  // word_adr must already have bits [1:0] cleared.
  function automatic region_e decode_region(input logic [31:0] word_adr);
    region_e r;
    if (!word_adr[31]) begin
      r = REG_RAM;
    end else begin
      case (word_adr)
        TXDATA_ADDR: r = REG_TX;
        STATUS_ADDR: r = REG_STATUS;
        CYCLES_ADDR: r = REG_CYCLES;
        default:     r = REG_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/xrisc_sync_fifo.sv
// xrisc_sync_fifo
//   Single-clock FIFO, WIDTH bits x DEPTH entries (DEPTH a power of 2, >= 2).
//   A push while full is accepted only if a pop happens in the same cycle;
//   otherwise it is dropped and reported on 'drop' for one cycle.
//   A pop while empty is ignored.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push, push_data write strobe and data
//   pop             read strobe (head advances at posedge)
//   head_data       current head entry, 0 when empty
//   full, empty     occupancy flags
//   count           number of stored entries, 0..DEPTH
//   drop            push rejected this cycle (full, no pop)
module xrisc_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW:0]   CNT_DEPTH = DEPTH;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_DEPTH);
  assign count = count_q;

  // A pop frees the slot the simultaneous push needs, so full+push+pop succeeds.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; head_data is masked while empty, so stale entries are never visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/xrisc_dmem_mmio.sv
// xrisc_dmem_mmio
//   Data-port responder for the single-cycle core: word-addressed RAM, an MMIO
//   window (TX FIFO, STATUS, free-running CYCLES counter) and a sticky
//   done/pass detector for the "store PASS_VALUE to DONE_ADDR" self-check.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   MemWrite             store strobe
//   DataAdr              byte address, bits [1:0] ignored
//   WriteData            store data
//   ReadData             combinational load data (state before this edge)
//   out_valid/out_data   TX FIFO head toward host
//   out_ready            host accepts head when out_valid
//   done, pass           sticky test-end flags
module xrisc_dmem_mmio
  import xrisc_mmio_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] DONE_ADDR  = 32'd100,
  parameter logic [31:0] PASS_VALUE = 32'd25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        done,
  output logic        pass
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       word_adr;
  region_e           region;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_byte_sel;

  logic [31:0] ram_q [RAM_WORDS];
  logic [31:0] ram_d [RAM_WORDS];
  logic [31:0] cycles_q, cycles_d;
  logic        overflow_q, overflow_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      fifo_head;
  logic [31:0]      status_word;

  assign word_adr        = {DataAdr[31:2], 2'b00};
  assign unused_byte_sel = ^DataAdr[1:0];
  assign region          = decode_region(word_adr);
  // Upper RAM-region address bits are don't-care: the RAM aliases across the low half.
  assign ram_idx         = DataAdr[RAM_AW+1:2];

  assign fifo_push = MemWrite && (region == REG_TX);
  assign fifo_pop  = out_valid && out_ready;

  xrisc_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (WriteData),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head;
  assign done      = done_q;
  assign pass      = pass_q;

  always_comb begin
    status_word                                   = '0;
    status_word[STAT_OVERFLOW_BIT]                = overflow_q;
    status_word[STAT_FULL_BIT]                    = fifo_full;
    status_word[STAT_EMPTY_BIT]                   = fifo_empty;
    status_word[STAT_COUNT_LSB +: STAT_COUNT_W]   = STAT_COUNT_W'(fifo_count);
  end

  always_comb begin
    ReadData = '0;
    case (region)
      REG_RAM:    ReadData = ram_q[ram_idx];
      REG_STATUS: ReadData = status_word;
      REG_CYCLES: ReadData = cycles_q;
      default:    ReadData = '0;
    endcase
  end

  always_comb begin
    ram_d      = ram_q;
    cycles_d   = cycles_q + 32'd1;
    overflow_d = overflow_q;
    done_d     = done_q;
    pass_d     = pass_q;

    if (MemWrite) begin
      case (region)
        REG_RAM:    ram_d[ram_idx] = WriteData;
        REG_STATUS: if (WriteData[0]) overflow_d = 1'b0;
        REG_CYCLES: cycles_d = WriteData;
        default:    ;
      endcase
    end

    // Drop and STATUS clear cannot coincide: they need different addresses.
    if (fifo_drop) overflow_d = 1'b1;

    // Only the first finishing store counts; later ones leave both flags alone.
    if (MemWrite && (word_adr == DONE_ADDR) && !done_q) begin
      done_d = 1'b1;
      pass_d = (WriteData == PASS_VALUE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RAM_WORDS; i++) ram_q[i] <= '0;
      cycles_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      ram_q      <= ram_d;
      cycles_q   <= cycles_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

endmodule

// File: tb/tb_xrisc_dmem_mmio.sv
// tb_xrisc_dmem_mmio
//   Table-driven vectors, hand-written FIFO / counter / done-pass / reset
//   sequences, and a randomized run against a queue-based reference model.
module tb_xrisc_dmem_mmio;

  localparam logic [31:0] A_TX  = 32'h8000_0000;
  localparam logic [31:0] A_ST  = 32'h8000_0004;
  localparam logic [31:0] A_CYC = 32'h8000_0008;
  localparam logic [31:0] A_NIL = 32'h8000_0010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        done;
  logic        pass;

  int n_checks = 0;
  int n_fail   = 0;

  xrisc_dmem_mmio dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .done      (done),
    .pass      (pass)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge; outputs are sampled 1 unit later.
  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    @(negedge clk);
    MemWrite  = we;
    DataAdr   = a;
    WriteData = wd;
    out_ready = rdy;
    #1;
  endtask

  // Short reset pulse between edges; leaves DataAdr on CYCLES for a reset-state look.
  task automatic do_reset();
    @(negedge clk);
    MemWrite  = 1'b0;
    out_ready = 1'b0;
    WriteData = '0;
    DataAdr   = A_CYC;
    reset     = 1'b1;
    #1;
    reset     = 1'b0;
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_ram [64];
  logic [31:0] m_q [$];
  bit          m_ovf, m_done, m_pass;
  logic [31:0] m_cyc;

  task automatic model_reset();
    foreach (m_ram[i]) m_ram[i] = '0;
    m_q.delete();
    m_ovf  = 0;
    m_done = 0;
    m_pass = 0;
    m_cyc  = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w;
    int          sz;
    w  = a & ~32'h3;
    sz = m_q.size();
    if (a < 32'h8000_0000) return m_ram[int'((a / 4) % 64)];
    if (w == A_ST)
      return 32'(sz) + (sz == 0 ? 32 : 0) + (sz == 4 ? 64 : 0) + (m_ovf ? 128 : 0);
    if (w == A_CYC) return m_cyc;
    return 32'h0;
  endfunction

  task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    logic [31:0] w;
    bit          pop, push;
    w    = a & ~32'h3;
    pop  = (m_q.size() > 0) && rdy;
    push = 0;
    m_cyc = m_cyc + 1;
    if (we) begin
      if (a < 32'h8000_0000) m_ram[int'((a / 4) % 64)] = wd;
      else if (w == A_TX) begin
        if (m_q.size() < 4 || pop) push = 1;
        else m_ovf = 1;
      end else if (w == A_ST) begin
        if (wd % 2 == 1) m_ovf = 0;
      end else if (w == A_CYC) m_cyc = wd;
      if (w == 32'd100 && !m_done) begin
        m_done = 1;
        m_pass = (wd == 32'd25);
      end
    end
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(wd);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] exp_drain [4];

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_0110, 32'h0,         32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, A_TX,          32'h0,         32'h0};
    vecs[5]  = '{1'b0, A_ST,          32'h0,         32'h0000_0020};
    vecs[6]  = '{1'b1, 32'h8000_000C, 32'h5,         32'h0};
    vecs[7]  = '{1'b0, 32'h8000_000C, 32'h0,         32'h0};
    vecs[8]  = '{1'b1, 32'h0000_0014, 32'h1234_5678, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0114, 32'h0,         32'h1234_5678};
    vecs[10] = '{1'b0, 32'h4000_0010, 32'h0,         32'hDEAD_BEEF};

    // Reset state
    do_reset();
    check("reset_cycles", ReadData, 32'h0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 32'h0);
    check("reset_done", done, 1'b0);
    check("reset_pass", pass, 1'b0);

    // RAM / decode table
    for (int i = 0; i < 11; i++) begin
      cyc(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0);
      check($sformatf("vec%0d_rdata", i), ReadData, vecs[i].exp_rdata);
    end

    // FIFO overflow then drain
    do_reset();
    for (int v = 1; v <= 5; v++) cyc(1'b1, A_TX, 32'(v), 1'b0);
    cyc(1'b0, A_ST, 32'h0, 1'b0);
    check("ovf_status", ReadData, 32'h0000_00C4);
    check("ovf_valid", out_valid, 1'b1);
    cyc(1'b1, A_ST, 32'h1, 1'b0);
    cyc(1'b0, A_ST, 32'h0, 1'b0);
    check("ovf_cleared", ReadData, 32'h0000_0044);
    for (int v = 1; v <= 4; v++) begin
      cyc(1'b0, A_NIL, 32'h0, 1'b1);
      check($sformatf("drain_valid%0d", v), out_valid, 1'b1);
      check($sformatf("drain_data%0d", v), out_data, 32'(v));
    end
    cyc(1'b0, A_ST, 32'h0, 1'b0);
    check("drained_valid", out_valid, 1'b0);
    check("drained_data", out_data, 32'h0);
    check("drained_status", ReadData, 32'h0000_0020);

    // Full with simultaneous push and pop
    for (int v = 11; v <= 14; v++) cyc(1'b1, A_TX, 32'(v), 1'b0);
    cyc(1'b1, A_TX, 32'h9, 1'b1);
    check("fullpp_head", out_data, 32'd11);
    cyc(1'b0, A_ST, 32'h0, 1'b0);
    check("fullpp_status", ReadData, 32'h0000_0044);
    exp_drain = '{32'd12, 32'd13, 32'd14, 32'd9};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, A_ST, 32'h0, 1'b1);
      check($sformatf("fullpp_drain%0d", i), out_data, exp_drain[i]);
    end
    cyc(1'b0, A_ST, 32'h0, 1'b0);
    check("fullpp_empty", ReadData, 32'h0000_0020);

    // Empty with simultaneous push and pop: pop ignored
    cyc(1'b1, A_TX, 32'h55, 1'b1);
    check("emptypp_valid", out_valid, 1'b0);
    cyc(1'b0, A_ST, 32'h0, 1'b0);
    check("emptypp_status", ReadData, 32'h0000_0001);
    check("emptypp_head", out_data, 32'h55);
    cyc(1'b0, A_ST, 32'h0, 1'b1);
    cyc(1'b0, A_ST, 32'h0, 1'b0);
    check("emptypp_drained", ReadData, 32'h0000_0020);

    // Cycle counter load and wrap
    cyc(1'b1, A_CYC, 32'hFF, 1'b0);
    cyc(1'b0, A_CYC, 32'h0, 1'b0);
    check("cyc_load", ReadData, 32'hFF);
    cyc(1'b0, A_CYC, 32'h0, 1'b0);
    check("cyc_incr", ReadData, 32'h100);
    cyc(1'b1, A_CYC, 32'hFFFF_FFFF, 1'b0);
    cyc(1'b0, A_CYC, 32'h0, 1'b0);
    check("cyc_max", ReadData, 32'hFFFF_FFFF);
    cyc(1'b0, A_CYC, 32'h0, 1'b0);
    check("cyc_wrap", ReadData, 32'h0);

    // Done/pass: passing run, then a later store must not disturb flags
    check("pre_done", done, 1'b0);
    cyc(1'b1, 32'd100, 32'd25, 1'b0);
    check("done_same_cycle", done, 1'b0);
    cyc(1'b0, 32'd100, 32'h0, 1'b0);
    check("pass_done", done, 1'b1);
    check("pass_pass", pass, 1'b1);
    check("pass_ram", ReadData, 32'd25);
    cyc(1'b1, 32'd100, 32'd7, 1'b0);
    cyc(1'b0, 32'd100, 32'h0, 1'b0);
    check("later_done", done, 1'b1);
    check("later_pass", pass, 1'b1);
    check("later_ram", ReadData, 32'd7);

    // Failing run
    do_reset();
    cyc(1'b1, 32'd100, 32'd24, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0);
    check("fail_done", done, 1'b1);
    check("fail_pass", pass, 1'b0);
    cyc(1'b1, 32'd100, 32'd25, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0);
    check("fail_sticky_pass", pass, 1'b0);

    // Randomized run against the model
    do_reset();
    model_reset();
    model_step(1'b0, A_CYC, 32'h0, 1'b0);
    for (int it = 0; it < 300; it++) begin
      logic [31:0] a, wd;
      logic        we, rdy;
      case ($urandom_range(0, 7))
        0, 1: a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3) * 256);
        2:    a = 32'd100;
        3, 4: a = A_TX;
        5:    a = A_ST;
        6:    a = A_CYC;
        default: a = A_NIL + 32'($urandom_range(0, 1000) * 4);
      endcase
      a   = a | 32'($urandom_range(0, 3));
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      if (a[31:2] == 30'd25 && $urandom_range(0, 1) == 1) wd = 32'd25;
      rdy = ($urandom_range(0, 2) == 0);
      cyc(we, a, wd, rdy);
      check($sformatf("rnd%0d_rdata", it), ReadData, model_read(a));
      check($sformatf("rnd%0d_valid", it), out_valid, m_q.size() > 0);
      check($sformatf("rnd%0d_data", it), out_data, m_q.size() > 0 ? m_q[0] : 32'h0);
      check($sformatf("rnd%0d_done", it), done, m_done);
      check($sformatf("rnd%0d_pass", it), pass, m_pass);
      model_step(we, a, wd, rdy);
    end

    // Asynchronous reset mid-drain, between clock edges
    do_reset();
    cyc(1'b1, 32'h10, 32'hCAFE_F00D, 1'b0);
    cyc(1'b1, A_TX, 32'hA1, 1'b0);
    cyc(1'b1, A_TX, 32'hA2, 1'b0);
    cyc(1'b1, 32'd100, 32'd25, 1'b0);
    cyc(1'b0, 32'h10, 32'h0, 1'b1);
    check("pre_rst_ram", ReadData, 32'hCAFE_F00D);
    check("pre_rst_done", done, 1'b1);
    cyc(1'b0, A_ST, 32'h0, 1'b1);
    check("pre_rst_head", out_data, 32'hA2);
    reset = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 1'b0);
    check("rst_async_done", done, 1'b0);
    check("rst_async_pass", pass, 1'b0);
    check("rst_async_status", ReadData, 32'h0000_0020);
    DataAdr = 32'h10;
    #1;
    check("rst_async_ram", ReadData, 32'h0);
    #1;
    reset = 1'b0;
    cyc(1'b0, A_ST, 32'h0, 1'b1);
    check("post_rst_valid", out_valid, 1'b0);
    check("post_rst_status", ReadData, 32'h0000_0020);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
